rx_bram_ctrl: RTL and testbench
===============================

Name: rx_bram_ctrl

Overview:
Sequencer for the 16x512 receive sample BRAM. Writes incoming ADC samples continuously into the BRAM as a circular buffer. Serves burst-read requests from the correlator/detector stage through a request/busy handshake and a valid-qualified output stream. Sits between the rx front-end sample stream and the BRAM's port A (write) and port B (read).

Parameters:
DATA_W, 16, sample width
ADDR_W, 9, BRAM address width
DEPTH, 512, buffer depth in samples (2**ADDR_W)

Ports:
clk  in  1  system clock
rrx_rst  in  1  asynchronous active-high reset
sample_valid  in  1  sample_in valid this cycle
sample_in  in  DATA_W  received sample
rd_req  in  1  burst-read request, single-cycle pulse, sampled only when rd_busy=0
rd_start  in  ADDR_W  absolute start address of the burst
rd_len  in  ADDR_W+1  burst length, 1..DEPTH
rd_busy  out  1  burst in progress
rd_err  out  1  one-cycle pulse: request rejected
rd_valid  out  1  rd_data valid
rd_data  out  DATA_W  burst sample
rd_last  out  1  final sample of the burst, coincident with rd_valid
wr_ptr  out  ADDR_W  next write address
fill_count  out  ADDR_W+1  samples written since reset, saturating at DEPTH
bram_ena  out  1  BRAM port A enable
bram_wea  out  1  BRAM write enable
bram_addra  out  ADDR_W  BRAM write address
bram_dia  out  DATA_W  BRAM write data
bram_enb  out  1  BRAM read enable
bram_addrb  out  ADDR_W  BRAM read address
bram_dob  in  DATA_W  BRAM read data, registered, 1-cycle latency

Behaviour:
- Reset: rrx_rst is asynchronous and active-high. While it is asserted, all registered state and outputs are 0: rd_busy, rd_err, rd_valid, rd_data, rd_last, wr_ptr, fill_count and all bram_* outputs. The FSM goes to IDLE.
- Write path is combinational from the inputs: bram_ena = bram_wea = sample_valid, bram_addra = wr_ptr, bram_dia = sample_in.
- On each sample_valid, wr_ptr increments; 511 wraps to 0. fill_count increments and saturates at DEPTH.
- FSM states: IDLE, READ, FLUSH.
- IDLE -> READ: on rd_req with 1 <= rd_len <= fill_count. Latch rd_start as the read address and rd_len as the remaining count. Assert rd_busy from the next cycle.
- IDLE, rejected request: rd_req with rd_len = 0, rd_len > DEPTH, or rd_len > fill_count gives a one-cycle rd_err pulse on the next cycle. The FSM stays in IDLE.
- READ: each cycle, bram_enb = 1 and bram_addrb = read address. Then the address increments (511 wraps to 0) and the remaining count decrements. When the count reaches 0 after the final issue, go to FLUSH.
- FLUSH: bram_enb = 0. The last sample returns this cycle. Go to IDLE; rd_busy deasserts on the transition.
- Output timing: rd_valid is bram_enb delayed 1 cycle, rd_data = bram_dob, and rd_last is the last-issue flag delayed 1 cycle.
- Latency: the first rd_valid comes 2 cycles after the rd_req cycle. The burst is gap-free, with exactly rd_len valid beats.
- rd_req while rd_busy = 1 is ignored: no error and no effect.
- The next rd_req is accepted the cycle rd_busy is observed low.
- A simultaneous write and read to the same address returns the old (pre-write) data.
- Writes overwriting unread burst data are the caller's responsibility; the block does not check for this.
- Reset mid-burst aborts immediately. No further rd_valid is produced; the BRAM contents are untouched.
- Writes and reads proceed concurrently without stalls.

Test Plan:
- Reset, then 8 samples 0x0001..0x0008 at addresses 0..7 -> wr_ptr=8, fill_count=8; bram_addra/bram_dia match each cycle.
- rd_req with rd_start=2, rd_len=4 -> rd_busy high; 4 consecutive rd_valid beats 0x0003..0x0006, first beat 2 cycles after the request; rd_last on beat 4; rd_busy low after FLUSH.
- Write 520 samples (value = index) -> fill_count saturates at 512, wr_ptr=8. rd_start=510, rd_len=4 -> data 510, 511, 512, 513 read from addresses 510, 511, 0, 1.
- rd_req with rd_len=0, and separately rd_len=9 while fill_count=8 -> one-cycle rd_err each; no rd_valid; FSM stays in IDLE. rd_req during an active burst -> ignored.
- Continuous sample_valid during a 16-beat burst -> no write stall and no read gap; a read of the address being written that cycle returns the old value.
- Assert rrx_rst asynchronously mid-burst, between clock edges -> rd_valid, rd_busy, wr_ptr and fill_count go to 0 immediately; after release, the next valid request works normally.

Source files
------------

// File: rtl/rx_bram_ctrl.sv
// Receive sample BRAM sequencer: circular-buffer writer on port A and
// request/busy burst reader on port B with a valid-qualified output stream.
module rx_bram_ctrl #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rrx_rst,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_start,
  input  logic [ADDR_W:0]   rd_len,
  output logic              rd_busy,
  output logic              rd_err,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W:0]   fill_count,
  output logic              bram_ena,
  output logic              bram_wea,
  output logic [ADDR_W-1:0] bram_addra,
  output logic [DATA_W-1:0] bram_dia,
  output logic              bram_enb,
  output logic [ADDR_W-1:0] bram_addrb,
  input  logic [DATA_W-1:0] bram_dob
);

  localparam int unsigned      CNT_W   = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  fill_q, fill_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic              bram_enb_q, bram_enb_d;
  logic              rd_err_q, rd_err_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_last_q, rd_last_d;
  logic              req_ok;

  // Write side: pointer and saturating fill counter
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    if (sample_valid) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (fill_q != DEPTH_C) begin
        fill_d = fill_q + CNT_W'(1);
      end
    end
  end

  assign req_ok = (rd_len != '0) && (rd_len <= DEPTH_C) && (rd_len <= fill_q);

  // Read FSM: next state, burst address/count, and the registered issue/return flags
  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    rd_cnt_d   = rd_cnt_q;
    rd_err_d   = 1'b0;
    rd_valid_d = bram_enb_q;
    rd_last_d  = bram_enb_q && (rd_cnt_q == CNT_W'(1));
    unique case (state_q)
      IDLE: begin
        if (rd_req) begin
          if (req_ok) begin
            state_d   = READ;
            rd_addr_d = rd_start;
            rd_cnt_d  = rd_len;
          end else begin
            rd_err_d = 1'b1;
          end
        end
      end
      READ: begin
        rd_addr_d = rd_addr_q + ADDR_W'(1);
        rd_cnt_d  = rd_cnt_q - CNT_W'(1);
        if (rd_cnt_d == '0) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    bram_enb_d = (state_d == READ);
  end

  always_ff @(posedge clk or posedge rrx_rst) begin
    if (rrx_rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      rd_addr_q  <= '0;
      rd_cnt_q   <= '0;
      bram_enb_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_q     <= fill_d;
      rd_addr_q  <= rd_addr_d;
      rd_cnt_q   <= rd_cnt_d;
      bram_enb_q <= bram_enb_d;
      rd_err_q   <= rd_err_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
    end
  end

  // Port A follows the sample stream directly; held quiet while in reset
  assign bram_ena   = sample_valid & ~rrx_rst;
  assign bram_wea   = sample_valid & ~rrx_rst;
  assign bram_addra = wr_ptr_q;
  assign bram_dia   = rrx_rst ? '0 : sample_in;

  assign bram_enb   = bram_enb_q;
  assign bram_addrb = rd_addr_q;

  assign rd_busy    = (state_q != IDLE);
  assign rd_err     = rd_err_q;
  assign rd_valid   = rd_valid_q;
  assign rd_last    = rd_last_q;
  // Port B data is already registered inside the BRAM; qualify it with rd_valid
  assign rd_data    = rd_valid_q ? bram_dob : '0;
  assign wr_ptr     = wr_ptr_q;
  assign fill_count = fill_q;

endmodule

// File: tb/tb_rx_bram_ctrl.sv
// Directed bench for rx_bram_ctrl with a read-first dual-port BRAM model.
module tb_rx_bram_ctrl;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DEPTH  = 512;

  logic              clk = 1'b0;
  logic              rrx_rst;
  logic              sample_valid;
  logic [DATA_W-1:0] sample_in;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_start;
  logic [ADDR_W:0]   rd_len;
  logic              rd_busy, rd_err, rd_valid, rd_last;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   fill_count;
  logic              bram_ena, bram_wea, bram_enb;
  logic [ADDR_W-1:0] bram_addra, bram_addrb;
  logic [DATA_W-1:0] bram_dia;
  logic [DATA_W-1:0] bram_dob = '0;

  logic [DATA_W-1:0] mem [DEPTH];

  int n_checks = 0;
  int n_errors = 0;

  rx_bram_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rrx_rst(rrx_rst),
    .sample_valid(sample_valid), .sample_in(sample_in),
    .rd_req(rd_req), .rd_start(rd_start), .rd_len(rd_len),
    .rd_busy(rd_busy), .rd_err(rd_err), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_last(rd_last),
    .wr_ptr(wr_ptr), .fill_count(fill_count),
    .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_addra(bram_addra), .bram_dia(bram_dia),
    .bram_enb(bram_enb), .bram_addrb(bram_addrb), .bram_dob(bram_dob)
  );

  always #5 clk = ~clk;

  // Read-first BRAM: a same-address read and write in one cycle returns old data
  always @(posedge clk) begin
    if (bram_enb) bram_dob <= mem[bram_addrb];
    if (bram_ena && bram_wea) mem[bram_addra] <= bram_dia;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [DATA_W-1:0] din;
    logic [ADDR_W-1:0] exp_addra;
    logic [ADDR_W-1:0] exp_ptr;
    logic [ADDR_W:0]   exp_fill;
  } wr_vec_t;

  typedef struct {
    logic [ADDR_W-1:0] start;
    logic [ADDR_W:0]   len;
    bit                err;
    logic [DATA_W-1:0] first;
  } req_vec_t;

  wr_vec_t  wv [8];
  req_vec_t rv [6];

  // Issue one accepted burst; optional ignored requests while busy and a concurrent write stream
  task automatic burst(input logic [ADDR_W-1:0] start, input logic [ADDR_W:0] len,
                       input logic [DATA_W-1:0] first, input bit inject,
                       input bit wr_en, input logic [DATA_W-1:0] wr_base);
    int beats, first_cyc, n_wr, ilen;
    bit busy_ok, enb_ok, addr_ok, stray_last, err_seen;
    beats = 0; first_cyc = -1; n_wr = 1; ilen = int'(len);
    busy_ok = 1; enb_ok = 1; addr_ok = 1; stray_last = 0; err_seen = 0;
    rd_req = 1'b1; rd_start = start; rd_len = len;
    sample_valid = wr_en; sample_in = wr_base;
    for (int cyc = 1; cyc <= ilen + 2; cyc++) begin
      step();
      rd_req = inject && (cyc <= 2);
      rd_len = inject ? '0 : len;
      sample_in = wr_base + DATA_W'(n_wr);
      if (wr_en) n_wr++;
      sample_valid = wr_en && (cyc <= ilen + 1);
      if (rd_err) err_seen = 1;
      if (cyc <= ilen + 1 && !rd_busy) busy_ok = 0;
      if (bram_enb != (cyc <= ilen)) enb_ok = 0;
      if (bram_enb && bram_addrb != ADDR_W'(int'(start) + cyc - 1)) addr_ok = 0;
      if (rd_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        chk("beat_data", 32'(rd_data), 32'(first + DATA_W'(beats)));
        chk("beat_last", 32'(rd_last), 32'(beats == ilen - 1));
        beats++;
      end else if (rd_last) begin
        stray_last = 1;
      end
    end
    sample_valid = 1'b0;
    rd_req = 1'b0;
    chk("beat_count", 32'(beats), 32'(ilen));
    chk("first_latency", 32'(first_cyc), 32'd2);
    chk("busy_during", 32'(busy_ok), 32'd1);
    chk("busy_end", 32'(rd_busy), 32'd0);
    chk("enb_window", 32'(enb_ok), 32'd1);
    chk("read_addr_seq", 32'(addr_ok), 32'd1);
    chk("stray_last", 32'(stray_last), 32'd0);
    chk("no_err_burst", 32'(err_seen), 32'd0);
  endtask

  task automatic reject(input logic [ADDR_W-1:0] start, input logic [ADDR_W:0] len);
    rd_req = 1'b1; rd_start = start; rd_len = len;
    step();
    rd_req = 1'b0;
    chk("rej_err_pulse", 32'(rd_err), 32'd1);
    chk("rej_busy", 32'(rd_busy), 32'd0);
    chk("rej_valid1", 32'(rd_valid), 32'd0);
    step();
    chk("rej_err_clear", 32'(rd_err), 32'd0);
    chk("rej_valid2", 32'(rd_valid | rd_busy | bram_enb), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      wv[i].din       = DATA_W'(i + 1);
      wv[i].exp_addra = ADDR_W'(i);
      wv[i].exp_ptr   = ADDR_W'(i + 1);
      wv[i].exp_fill  = (ADDR_W+1)'(i + 1);
    end
    // Buffer after the initial writes holds mem[a] = a+1 for a = 0..7, fill_count = 8
    rv[0] = '{start: 9'd2, len: 10'd4,   err: 1'b0, first: 16'h0003};
    rv[1] = '{start: 9'd0, len: 10'd0,   err: 1'b1, first: 16'h0000};
    rv[2] = '{start: 9'd0, len: 10'd9,   err: 1'b1, first: 16'h0000};
    rv[3] = '{start: 9'd7, len: 10'd1,   err: 1'b0, first: 16'h0008};
    rv[4] = '{start: 9'd0, len: 10'd8,   err: 1'b0, first: 16'h0001};
    rv[5] = '{start: 9'd3, len: 10'd600, err: 1'b1, first: 16'h0000};

    rrx_rst = 1'b1; sample_valid = 1'b1; sample_in = 16'hFFFF;
    rd_req = 1'b0; rd_start = '0; rd_len = '0;
    #3;
    chk("rst_wr_ptr", 32'(wr_ptr), 32'd0);
    chk("rst_fill", 32'(fill_count), 32'd0);
    chk("rst_outputs", 32'({rd_busy, rd_err, rd_valid, rd_last, bram_enb}), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_bram_a", 32'({bram_ena, bram_wea, bram_dia}), 32'd0);
    chk("rst_addrb", 32'(bram_addrb), 32'd0);
    step();
    sample_valid = 1'b0;
    step();
    rrx_rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) begin
      sample_valid = 1'b1; sample_in = wv[i].din;
      #1;
      chk("wr_ena", 32'({bram_ena, bram_wea}), 32'd3);
      chk("wr_addra", 32'(bram_addra), 32'(wv[i].exp_addra));
      chk("wr_dia", 32'(bram_dia), 32'(wv[i].din));
      step();
      chk("wr_ptr", 32'(wr_ptr), 32'(wv[i].exp_ptr));
      chk("wr_fill", 32'(fill_count), 32'(wv[i].exp_fill));
    end
    sample_valid = 1'b0;
    #1;
    chk("wr_idle_ena", 32'(bram_ena), 32'd0);

    for (int i = 0; i < 6; i++) begin
      if (rv[i].err) reject(rv[i].start, rv[i].len);
      else burst(rv[i].start, rv[i].len, rv[i].first, 1'b0, 1'b0, '0);
    end
    // Requests pulsed while busy (with an illegal length) must be ignored
    burst(9'd1, 10'd4, 16'h0002, 1'b1, 1'b0, '0);

    // Asynchronous reset between clock edges, mid-burst
    rd_req = 1'b1; rd_start = 9'd0; rd_len = 10'd8;
    step();
    rd_req = 1'b0;
    step();
    step();
    chk("pre_rst_valid", 32'(rd_valid), 32'd1);
    #2 rrx_rst = 1'b1;
    #1;
    chk("arst_valid", 32'(rd_valid), 32'd0);
    chk("arst_busy", 32'(rd_busy), 32'd0);
    chk("arst_wr_ptr", 32'(wr_ptr), 32'd0);
    chk("arst_fill", 32'(fill_count), 32'd0);
    chk("arst_enb", 32'(bram_enb), 32'd0);
    step();
    rrx_rst = 1'b0;
    step();
    chk("post_rst_quiet", 32'(rd_valid | rd_busy), 32'd0);
    reject(9'd0, 10'd1);

    // 520 samples of value = index: saturate fill_count and wrap wr_ptr
    for (int i = 0; i < 520; i++) begin
      sample_valid = 1'b1; sample_in = DATA_W'(i);
      step();
      if (i == 510) chk("fill_511", 32'(fill_count), 32'd511);
      if (i == 511) chk("wrap_ptr_0", 32'(wr_ptr), 32'd0);
    end
    sample_valid = 1'b0;
    chk("fill_sat", 32'(fill_count), 32'd512);
    chk("wr_ptr_wrapped", 32'(wr_ptr), 32'd8);

    burst(9'd510, 10'd4, 16'd510, 1'b0, 1'b0, '0);
    burst(9'd8, 10'd512, 16'd8, 1'b0, 1'b0, '0);

    // Continuous writes colliding with each read address: old data comes back
    burst(9'd9, 10'd16, 16'd9, 1'b0, 1'b1, 16'hA000);
    chk("wr_no_stall", 32'(wr_ptr), 32'd26);
    chk("fill_hold", 32'(fill_count), 32'd512);
    burst(9'd8, 10'd4, 16'hA000, 1'b0, 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
